// File: rtl/busca_pkg.sv
// Shared definitions for the binary-search guess engine: FSM state encoding
// and default sizing constants.
package busca_pkg;

    localparam int N_PADRAO       = 8;
    localparam int TENT_W_PADRAO  = 4;
    localparam int TIMEOUT_PADRAO = 255;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        PROPOE  = 2'd2,
        FIM     = 2'd3
    } estado_t;

endpackage

// File: rtl/busca_limites.sv
// Search interval [lo, hi] for the binary-search engine. Provides the
// midpoint of the current interval and flags telling the FSM whether a
// "maior" or "menor" answer would leave the interval empty (or run past
// the ends of the N-bit range).
module busca_limites #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inicia,
    input  logic         sobe,
    input  logic         desce,
    input  logic [N-1:0] candidato,
    output logic [N-1:0] meio,
    output logic         maior_invalido,
    output logic         menor_invalido
);

    localparam logic [N-1:0] MAXIMO = '1;

    logic [N-1:0] lo;
    logic [N-1:0] hi;
    logic [N:0]   soma;
    logic [N:0]   cand_mais_um;
    logic [N-1:0] cand_menos_um;

    // Midpoint at N+1 bits so lo+hi never overflows.
    always_comb begin
        soma          = {1'b0, lo} + {1'b0, hi};
        meio          = soma[N:1];
        cand_mais_um  = {1'b0, candidato} + {{N{1'b0}}, 1'b1};
        cand_menos_um = candidato - {{(N-1){1'b0}}, 1'b1};
    end

    // Edge and empty-interval detection for the two narrowing answers.
    always_comb begin
        maior_invalido = (candidato == MAXIMO) || (cand_mais_um > {1'b0, hi});
        menor_invalido = (candidato == '0)     || (lo > cand_menos_um);
    end

    // Interval registers: reopened on start, narrowed on accepted answers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lo <= '0;
            hi <= MAXIMO;
        end else if (inicia) begin
            lo <= '0;
            hi <= MAXIMO;
        end else if (sobe) begin
            lo <= cand_mais_um[N-1:0];
        end else if (desce) begin
            hi <= cand_menos_um;
        end
    end

endmodule

// File: rtl/busca_binaria_8bit.sv
// Binary-search guess engine. Proposes candidates to an external comparator
// holding a hidden target and narrows the interval from its igual/maior/menor
// answers. Optional macro BUSCA_TIMEOUT_EN adds a TIMEOUT parameter that
// aborts a proposal left unanswered for TIMEOUT cycles.
module busca_binaria_8bit
    import busca_pkg::*;
#(
    parameter int N      = N_PADRAO,
    parameter int TENT_W = TENT_W_PADRAO
`ifdef BUSCA_TIMEOUT_EN
    ,
    parameter int TIMEOUT = TIMEOUT_PADRAO
`endif
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              iniciar,
    output logic [N-1:0]      candidato,
    output logic              cand_valido,
    input  logic              resp_valida,
    input  logic              igual,
    input  logic              maior,
    input  logic              menor,
    output logic              pronto,
    output logic              encontrado,
    output logic [N-1:0]      resultado,
    output logic [TENT_W-1:0] tentativas,
    output logic              erro
);

    estado_t      estado;
    logic [N-1:0] meio;
    logic         maior_invalido;
    logic         menor_invalido;
    logic         aceita;
    logic         so_igual;
    logic         so_maior;
    logic         so_menor;
    logic         inicia;
    logic         sobe;
    logic         desce;

`ifdef BUSCA_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] timer;
`endif

    // Answer decode: exactly one flag must be set for a well-formed answer.
    always_comb begin
        aceita   = (estado == PROPOE) && resp_valida;
        so_igual = igual  && !maior && !menor;
        so_maior = maior  && !igual && !menor;
        so_menor = menor  && !igual && !maior;
        inicia   = (estado == OCIOSO) && iniciar;
        sobe     = aceita && so_maior && !maior_invalido;
        desce    = aceita && so_menor && !menor_invalido;
    end

    busca_limites #(
        .N(N)
    ) u_limites (
        .clock          (clock),
        .reset_n        (reset_n),
        .inicia         (inicia),
        .sobe           (sobe),
        .desce          (desce),
        .candidato      (candidato),
        .meio           (meio),
        .maior_invalido (maior_invalido),
        .menor_invalido (menor_invalido)
    );

    // Search FSM with all outputs registered; pronto defaults low so it is a
    // single-cycle pulse coinciding with the FIM state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado      <= OCIOSO;
            candidato   <= '0;
            cand_valido <= 1'b0;
            pronto      <= 1'b0;
            encontrado  <= 1'b0;
            resultado   <= '0;
            tentativas  <= '0;
            erro        <= 1'b0;
`ifdef BUSCA_TIMEOUT_EN
            timer       <= '0;
`endif
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        encontrado <= 1'b0;
                        erro       <= 1'b0;
                        resultado  <= '0;
                        tentativas <= '0;
                        estado     <= CALCULA;
                    end
                end
                CALCULA: begin
                    candidato   <= meio;
                    cand_valido <= 1'b1;
`ifdef BUSCA_TIMEOUT_EN
                    timer       <= '0;
`endif
                    estado      <= PROPOE;
                end
                PROPOE: begin
                    if (resp_valida) begin
                        tentativas  <= tentativas + {{(TENT_W-1){1'b0}}, 1'b1};
                        cand_valido <= 1'b0;
                        if (so_igual) begin
                            resultado  <= candidato;
                            encontrado <= 1'b1;
                            pronto     <= 1'b1;
                            estado     <= FIM;
                        end else if ((so_maior && !maior_invalido) ||
                                     (so_menor && !menor_invalido)) begin
                            estado <= CALCULA;
                        end else begin
                            erro   <= 1'b1;
                            pronto <= 1'b1;
                            estado <= FIM;
                        end
                    end
`ifdef BUSCA_TIMEOUT_EN
                    else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        cand_valido <= 1'b0;
                        erro        <= 1'b1;
                        pronto      <= 1'b1;
                        estado      <= FIM;
                    end else begin
                        timer <= timer + {{(TMR_W-1){1'b0}}, 1'b1};
                    end
`endif
                end
                FIM: begin
                    estado <= OCIOSO;
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule
